operand_loader: RTL

//  Write side of the approximate-multiplier input memory: accepts 16-bit operand words over a

---
 rtl/operand_loader_if.sv | 21 ++
 rtl/operand_loader.sv | 100 ++++++++++
 2 files changed

// File: rtl/operand_loader_if.sv
// Operand word stream: a producer presents valid/data, the loader answers with ready.
// A word transfers on any rising edge where valid and ready are both high.
interface operand_loader_if #(
    parameter int WORD_W = 16
);
    logic              valid;
    logic              ready;
    logic [WORD_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/operand_loader.sv
// Write side of the approximate-multiplier input memory: packs a batch of DEPTH stream words
// into sequential addresses, kicks the controller with start, then waits for done.
module operand_loader #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    operand_loader_if.slave   stream,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              start,
    input  logic              done,
    output logic              busy,
    output logic [7:0]        batch_cnt
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_reg,     state_next;
    logic [ADDR_W-1:0] wr_cnt_reg,    wr_cnt_next;
    logic [7:0]        batch_cnt_reg, batch_cnt_next;
    logic              accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_FILL;
            wr_cnt_reg    <= '0;
            batch_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wr_cnt_reg    <= wr_cnt_next;
            batch_cnt_reg <= batch_cnt_next;
        end
    end

    // clear outranks everything: it also blocks the write because ready drops with it
    always_comb begin
        state_next     = state_reg;
        wr_cnt_next    = wr_cnt_reg;
        batch_cnt_next = batch_cnt_reg;
        if (clear) begin
            state_next  = ST_FILL;
            wr_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_FILL: begin
                    if (accept) begin
                        if (wr_cnt_reg == LAST_ADDR) begin
                            state_next  = ST_START;
                            wr_cnt_next = '0;
                        end else begin
                            wr_cnt_next = wr_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (done) begin
                        state_next     = ST_FILL;
                        batch_cnt_next = batch_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_next  = ST_FILL;
                    wr_cnt_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        stream.ready = (state_reg == ST_FILL) && !clear;
        accept       = stream.valid && stream.ready;
        mem_we       = accept;
        mem_addr     = wr_cnt_reg;
        mem_wdata    = stream.data;
        start        = (state_reg == ST_START) && !clear;
        busy         = (state_reg != ST_FILL);
        batch_cnt    = batch_cnt_reg;
    end

    a_start_only_in_start : assert property (
        @(posedge clk) disable iff (rst) start |-> (state_reg == ST_START));

    a_addr_in_range : assert property (
        @(posedge clk) disable iff (rst) mem_we |-> (int'(mem_addr) < DEPTH));

endmodule
